// File: rtl/fetch_stage_pkg.sv
// Shared sizing and encoding constants for the fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam int          DEF_ISIZE = 16;
    localparam int          DEF_ASIZE = 16;
    localparam logic [15:0] DEF_NOP   = 16'h0000;  // ADD R0,R0,R0
    localparam logic [3:0]  EXEC_TAG  = 4'hF;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, flush to a bubble, or hold.
module fetch_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int               ISIZE = DEF_ISIZE,
    parameter int               ASIZE = DEF_ASIZE,
    parameter logic [ISIZE-1:0] NOP   = DEF_NOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic             i_exec_bubble,
    input  logic [ISIZE-1:0] i_instr,
    input  logic [ASIZE-1:0] i_pc_link,
    output logic [ISIZE-1:0] o_instr,
    output logic [ASIZE-1:0] o_pc_link,
    output logic [ISIZE-1:0] o_last_instr,
    output logic [3:0]       o_exec_test,
    output logic             o_valid
);

    // Flush outranks load; with neither asserted every field holds. pc_link also
    // holds across a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_instr      <= NOP;
            o_pc_link    <= '0;
            o_last_instr <= NOP;
            o_exec_test  <= 4'h0;
            o_valid      <= 1'b0;
        end else if (i_flush) begin
            o_last_instr <= o_instr;
            o_instr      <= NOP;
            o_exec_test  <= i_exec_bubble ? EXEC_TAG : 4'h0;
            o_valid      <= 1'b0;
        end else if (i_load) begin
            // NOTE: non-blocking here lets last_instr capture the old instr_out in the same edge.
            o_last_instr <= o_instr;
            o_instr      <= i_instr;
            o_pc_link    <= i_pc_link;
            o_exec_test  <= 4'h0;
            o_valid      <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, EXEC one-shot sequencer and IF/ID register for the 16-bit CPU.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               ISIZE = DEF_ISIZE,
    parameter int               ASIZE = DEF_ASIZE,
    parameter logic [ISIZE-1:0] NOP   = DEF_NOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [ASIZE-1:0] redirect_pc,
    input  logic             exec_start,
    input  logic [ASIZE-1:0] exec_addr,
    output logic [ASIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_rdata,
    output logic [ISIZE-1:0] instr_out,
    output logic [ASIZE-1:0] pc_out,
    output logic [ISIZE-1:0] last_instr,
    output logic [3:0]       exec_test,
    output logic             valid_out
);

    typedef enum logic {RUN, EXEC_ONE} state_t;

    state_t           r_state;
    logic [ASIZE-1:0] r_pc;
    logic [ASIZE-1:0] r_ret_pc;

    logic w_exec_take;
    logic w_exec_bubble;
    logic w_flush;
    logic w_load;

    // EXEC is only honoured in RUN; the ID slot holds a bubble during EXEC_ONE.
    assign w_exec_take   = exec_start && (r_state == RUN);
    assign w_exec_bubble = w_exec_take && !redirect_valid;
    assign w_flush       = redirect_valid || w_exec_take;
    assign w_load        = !w_flush && !stall;
    assign imem_addr     = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_pc     <= '0;
            r_ret_pc <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= RUN;
        end else if (w_exec_take) begin
            r_ret_pc <= r_pc;
            r_pc     <= exec_addr;
            r_state  <= EXEC_ONE;
        end else if (!stall) begin
            if (r_state == EXEC_ONE) begin
                r_pc    <= r_ret_pc;
                r_state <= RUN;
            end else begin
                r_pc <= r_pc + ASIZE'(1);
            end
        end
    end

    // In EXEC_ONE r_pc equals exec_addr, so the link value is r_pc+1 in both states.
    fetch_if_id_reg #(
        .ISIZE (ISIZE),
        .ASIZE (ASIZE),
        .NOP   (NOP)
    ) u_if_id (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_load),
        .i_flush       (w_flush),
        .i_exec_bubble (w_exec_bubble),
        .i_instr       (imem_rdata),
        .i_pc_link     (r_pc + ASIZE'(1)),
        .o_instr       (instr_out),
        .o_pc_link     (pc_out),
        .o_last_instr  (last_instr),
        .o_exec_test   (exec_test),
        .o_valid       (valid_out)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed walk through the fetch scenarios, then random traffic.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        exec_start = 1'b0;
    logic [15:0] exec_addr = '0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [15:0] last_instr;
    logic [3:0]  exec_test;
    logic        valid_out;

    logic [15:0] mem [65536];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exec_start     (exec_start),
        .exec_addr      (exec_addr),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .last_instr     (last_instr),
        .exec_test      (exec_test),
        .valid_out      (valid_out)
    );

    int n_checks = 0;
    int n_passed = 0;
    int cyc      = 0;

    // Reference model: the program counter, a pending return address and the
    // three-stage view (issued-before, in-ID) of what decode should see.
    logic [15:0] m_pc, m_ret, m_instr, m_link, m_last;
    logic [3:0]  m_xt;
    logic        m_valid, m_in_exec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    endtask

    task automatic model_edge(input bit r, input bit s, input bit rv, input logic [15:0] rp,
                              input bit es, input logic [15:0] ea);
        if (r) begin
            m_pc = 0; m_ret = 0; m_instr = DEF_NOP; m_link = 0; m_last = DEF_NOP;
            m_xt = 0; m_valid = 0; m_in_exec = 0;
        end else if (rv) begin
            m_last = m_instr; m_instr = DEF_NOP; m_valid = 0; m_xt = 0;
            m_pc = rp; m_in_exec = 0;
        end else if (es && !m_in_exec) begin
            m_last = m_instr; m_instr = DEF_NOP; m_valid = 0; m_xt = 4'hF;
            m_ret = m_pc; m_pc = ea; m_in_exec = 1;
        end else if (!s) begin
            m_last  = m_instr;
            m_instr = mem[m_pc];
            m_link  = m_pc + 16'd1;
            m_valid = 1; m_xt = 0;
            m_pc    = m_in_exec ? m_ret : m_pc + 16'd1;
            m_in_exec = 0;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit rv, input logic [15:0] rp,
                        input bit es, input logic [15:0] ea);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        exec_start = es; exec_addr = ea;
        @(posedge clk);
        model_edge(r, s, rv, rp, es, ea);
        #1;
        cyc++;
        check("instr_out",  instr_out,  m_instr);
        check("pc_out",     pc_out,     m_link);
        check("last_instr", last_instr, m_last);
        check("exec_test",  exec_test,  m_xt);
        check("valid_out",  valid_out,  m_valid);
        check("imem_addr",  imem_addr,  m_pc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);

        // Reset, then free-run from address 0.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("reset_instr", instr_out, 16'h0000);
        step(0, 0, 0, 0, 0, 0);
        check("first_fetch", instr_out, 16'h1000);
        run(2);
        check("third_fetch", instr_out, 16'h1002);
        check("third_link",  pc_out,    16'h0003);

        // Stall for three edges with 1002 in ID, then resume.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        check("stall_hold", instr_out, 16'h1002);
        run(3);
        check("after_stall", instr_out, 16'h1005);

        // Redirect: one bubble, then target.
        step(0, 0, 1, 16'h0040, 0, 0);
        check("redir_bubble", valid_out, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        check("redir_target", instr_out, 16'h1040);

        // Place EXEC (address 0x10) in ID, then execute 0x80.
        step(0, 0, 1, 16'h0010, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0080);
        check("exec_bubble_tag", exec_test, 4'hF);
        step(0, 0, 0, 0, 0, 0);
        check("exec_instr", instr_out, 16'h1080);
        check("exec_link",  pc_out,    16'h0081);
        step(0, 0, 0, 0, 0, 0);
        check("exec_return", instr_out, 16'h1011);

        // Executed instruction is a taken branch; redirect also beats a stall.
        step(0, 0, 0, 0, 1, 16'h0090);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 16'h0200, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("branch_after_exec", instr_out, 16'h1200);

        // Address wrap at 0xFFFF.
        step(0, 0, 1, 16'hFFFE, 0, 0);
        run(2);
        check("wrap_link", pc_out, 16'h0000);
        run(1);
        check("wrap_fetch", instr_out, 16'h1000);

        // Reset in the middle of EXEC_ONE.
        step(0, 0, 0, 0, 1, 16'h0300);
        step(1, 0, 0, 0, 0, 0);
        check("mid_exec_reset", exec_test, 4'h0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic with scrambled memory contents.
        for (int i = 0; i < 256; i++) mem[$urandom_range(0, 65535)] = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            bit r, s, rv, es;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 20);
            rv = ($urandom_range(0, 99) < 10);
            es = ($urandom_range(0, 99) < 12) && !m_in_exec;
            step(r, s, rv, 16'($urandom), es, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
